// File: rtl/xor_descrambler_3b.sv
// ============================================================================
// Module   : xor_descrambler_3b
// Brief    : Recovers 3-bit plaintext words by XOR with a PRBS7 keystream,
//            valid/ready in and out, one-deep output register, word counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_descrambler_3b #(
    parameter logic [6:0] SEED_DEFAULT = 7'h01,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [6:0]       seed_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_data,
    output logic             running,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [6:0]       r_lfsr;
    logic             r_out_valid;
    logic [2:0]       r_out_data;
    logic [CNT_W-1:0] r_word_cnt;

    logic [6:0]       w_lfsr_next;
    logic [6:0]       w_seed_eff;
    logic             w_accept;

    // x^7 + x^6 + 1; an all-zero seed would lock the LFSR, so it maps to 1
    assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    assign w_seed_eff  = (seed_val == 7'h00) ? 7'h01 : seed_val;

    assign running   = (r_state == ST_RUN);
    assign in_ready  = running & ~seed_load & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign word_cnt  = r_word_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= SEED_DEFAULT;
            r_out_valid <= 1'b0;
            r_out_data  <= 3'b000;
            r_word_cnt  <= '0;
        end else begin
            // an accept can never coincide with seed_load (in_ready is low)
            if (seed_load) begin
                r_state    <= ST_RUN;
                r_lfsr     <= w_seed_eff;
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_lfsr <= w_lfsr_next;
                if (r_word_cnt != {CNT_W{1'b1}}) begin
                    r_word_cnt <= r_word_cnt + c_cnt_one;
                end
            end

            if (w_accept) begin
                r_out_data  <= in_data ^ r_lfsr[2:0];
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xor_descrambler_3b.sv
// ============================================================================
// Module   : tb_xor_descrambler_3b
// Brief    : Self-checking bench: behavioural model + directed literal checks
//            + randomized traffic for xor_descrambler_3b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_descrambler_3b;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [6:0]  seed_val = 7'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_data = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_data;
    logic        running;
    logic [15:0] word_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    xor_descrambler_3b #(.SEED_DEFAULT(7'h01), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .running   (running),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // PRBS7 state after n steps from seed s
    function automatic logic [6:0] prbs(input logic [6:0] s, input int n);
        logic [6:0] v = s;
        for (int i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_init = 0;
    bit          m_run;
    bit          m_ov;
    logic [2:0]  m_od;
    int          m_cnt;
    logic [6:0]  m_seed;
    int          m_n;

    always @(posedge clk) begin
        bit         acc;
        logic [6:0] st;
        if (rst) begin
            m_init = 1; m_run = 0; m_ov = 0; m_od = 3'b000;
            m_cnt = 0; m_seed = 7'h01; m_n = 0;
        end else if (m_init) begin
            acc = in_valid && m_run && !seed_load && (!m_ov || out_ready);
            if (seed_load) begin
                m_run = 1; m_seed = (seed_val == 7'h00) ? 7'h01 : seed_val;
                m_n = 0; m_cnt = 0;
            end
            if (acc) begin
                st    = prbs(m_seed, m_n);
                m_od  = in_data ^ st[2:0];
                m_n   = m_n + 1;
                m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                m_ov  = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready",  {31'd0, in_ready},
                  {31'd0, m_run && !seed_load && (!m_ov || out_ready)});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            check("running",   {31'd0, running},   {31'd0, m_run});
            check("word_cnt",  {16'd0, word_cnt},  m_cnt);
            if (m_ov) check("out_data", {29'd0, out_data}, {29'd0, m_od});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    initial begin
        logic [2:0] din [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
        logic [2:0] dexp[4] = '{3'b000, 3'b000, 3'b000, 3'b111};

        // reset, then in_valid without seed_load: nothing happens
        step; step; rst = 0; in_valid = 1; in_data = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step; #3;
            check("idle_in_ready", {31'd0, in_ready}, 0);
            check("idle_out_valid", {31'd0, out_valid}, 0);
            check("idle_word_cnt", {16'd0, word_cnt}, 0);
            check("idle_running", {31'd0, running}, 0);
        end
        check("reset_out_data", {29'd0, out_data}, 0);

        // back-to-back stream after seed 7'h01
        step; seed_load = 1; seed_val = 7'h01; in_valid = 0; out_ready = 1;
        step; seed_load = 0; in_valid = 1; in_data = din[0];
        for (int i = 0; i < 4; i++) begin
            step;
            if (i < 3) in_data = din[i+1];
            else in_valid = 0;
            #3;
            check("stream_out_data", {29'd0, out_data}, {29'd0, dexp[i]});
            check("stream_out_valid", {31'd0, out_valid}, 1);
        end
        check("stream_word_cnt", {16'd0, word_cnt}, 4);

        // zero seed substituted by 7'h01
        step; seed_load = 1; seed_val = 7'h00;
        step; seed_load = 0; in_valid = 1; in_data = 3'b000;
        step; in_valid = 0; #3;
        check("zero_seed_out", {29'd0, out_data}, 3'b001);

        // backpressure
        step; seed_load = 1; seed_val = 7'h01; out_ready = 0;
        step; seed_load = 0; in_valid = 1; in_data = 3'b011;
        step; in_data = 3'b111; #3;
        check("bp_out_valid", {31'd0, out_valid}, 1);
        check("bp_out_data", {29'd0, out_data}, 3'b010);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        for (int i = 0; i < 5; i++) begin
            step; #3;
            check("bp_hold_data", {29'd0, out_data}, 3'b010);
            check("bp_hold_ready", {31'd0, in_ready}, 0);
        end
        step; out_ready = 1; #3;
        check("bp_release_ready", {31'd0, in_ready}, 1);
        step; in_valid = 0; #3;
        check("bp_second_out", {29'd0, out_data}, 3'b101);
        check("bp_word_cnt", {16'd0, word_cnt}, 2);

        // seed_load collides with in_valid
        step; seed_load = 1; seed_val = 7'h01; in_valid = 1; in_data = 3'b110; #3;
        check("collide_in_ready", {31'd0, in_ready}, 0);
        step; seed_load = 0; #3;
        check("collide_next_ready", {31'd0, in_ready}, 1);
        step; in_valid = 0; #3;
        check("collide_out_data", {29'd0, out_data}, 3'b111);
        check("collide_word_cnt", {16'd0, word_cnt}, 1);

        // full keystream period, then reset mid-stream
        step; seed_load = 1; seed_val = 7'h01; out_ready = 1;
        step; seed_load = 0; in_valid = 1; in_data = 3'b000;
        for (int i = 0; i < 128; i++) begin
            step; #3;
            if (i == 0)   check("wrap_first", {29'd0, out_data}, 3'b001);
            if (i == 127) check("wrap_128th", {29'd0, out_data}, 3'b001);
        end
        check("wrap_valid_before_rst", {31'd0, out_valid}, 1);
        step; rst = 1;
        step; rst = 0; in_valid = 0; #3;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_running", {31'd0, running}, 0);
        check("rst_word_cnt", {16'd0, word_cnt}, 0);
        check("rst_out_data", {29'd0, out_data}, 0);

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            step;
            rst       = ($urandom_range(0, 299) == 0);
            seed_load = ($urandom_range(0, 39) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 3'($urandom);
        end
        step; rst = 0; seed_load = 0; in_valid = 0;
        step; #3;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xor_descrambler_3b.md
Name: xor_descrambler_3b

Overview:
- Receive end of the 3-bit XOR scrambling link.
- Accepts scrambled 3-bit words on a valid/ready stream and XORs each word with a PRBS7 keystream to recover plaintext.
- Sequence: keystream reseeded by a load command → stream runs → each recovered word goes through a one-deep output register.
- Sits between the link receive stage and downstream consumers. Also keeps a saturating count of recovered words.

Parameters:
SEED_DEFAULT, 7'h01, LFSR state loaded at reset (must be nonzero)
CNT_W, 16, width of recovered-word counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
seed_load  input  1  one-cycle pulse: load seed_val into LFSR, enter RUN
seed_val  input  7  seed for LFSR; 7'h00 substituted by 7'h01
in_valid  input  1  scrambled word valid
in_ready  output  1  block can accept word this cycle
in_data  input  3  scrambled word
out_valid  output  1  recovered word valid
out_ready  input  1  downstream accepts word
out_data  output  3  recovered word
running  output  1  1 in RUN state
word_cnt  output  CNT_W  recovered words accepted since last seed_load/reset, saturating

Behaviour:
- Decided: one clock (clk); reset rst synchronous, active-high.
- Reset (rst=1 at edge):
  - state=IDLE, lfsr=SEED_DEFAULT
  - out_valid=0, out_data=0, word_cnt=0, running=0
  - Reset overrides every other input that cycle, including mid-stream with out_valid=1; the pending word is discarded.
- FSM:
  - IDLE: in_ready=0. seed_load=1 → RUN.
  - RUN: normal operation. seed_load=1 → stays in RUN and reseeds.
  - There is no return to IDLE except by rst.
- LFSR (PRBS7, x^7+x^6+1):
  - Next state: lfsr_next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - Keystream k = lfsr[2:0].
  - Advances exactly one step per accepted input word, never otherwise.
- Seed load:
  - On seed_load=1: lfsr <= (seed_val==0 ? 7'h01 : seed_val), word_cnt <= 0.
  - The output register is not touched; a pending out word stays valid until it is taken.
- Input handshake:
  - in_ready = running & ~seed_load & (~out_valid | out_ready). This is combinational.
  - Accept when in_valid & in_ready.
  - On accept: out_data <= in_data ^ k, out_valid <= 1, lfsr <= lfsr_next, word_cnt <= word_cnt+1, holding at all-ones.
- Output handshake:
  - Latency is one cycle from accept to out_valid.
  - out_valid & out_ready with no new accept → out_valid <= 0.
  - Simultaneous take and accept → out_valid stays 1, out_data replaced. This gives full throughput of one word per cycle.
  - While out_valid=1 & out_ready=0: out_data is held stable and in_ready=0.
- seed_load in the same cycle as in_valid: the input is not accepted (in_ready=0). The word must be re-presented and is descrambled with the new seed.
- in_valid while IDLE: ignored, nothing accepted, LFSR unchanged.
- Keystream wrap: the period is 127 words. After 127 accepts from a given seed, lfsr equals that seed again.
- The same-seed scrambler on the transmit end uses an identical LFSR and XOR, so it XORs out to the original data.

Test Plan:
- Reset then in_valid=1, in_data=3'b101 for 3 cycles, no seed_load → in_ready=0 throughout, out_valid=0, word_cnt=0, running=0.
- seed_load with seed_val=7'h01, then feed in_data 3'b001, 3'b010, 3'b100, 3'b111 back-to-back with out_ready=1. Keystream is 001, 010, 100, 000. Required out_data: 000, 000, 000, 111, each one cycle after its accept; word_cnt=4.
- seed_val=7'h00 load, feed in_data=3'b000 → out_data=3'b001 (substituted seed 7'h01).
- Backpressure: seed 7'h01, accept 3'b011 with out_ready=0 → out_valid=1, out_data=3'b010, in_ready=0. Data held for 5 cycles, then out_ready=1 → next word accepted same cycle, and the LFSR advanced exactly once during the stall.
- seed_load asserted same cycle as in_valid (in_data=3'b110) with seed_val=7'h01 → not accepted. Next cycle accepted → out_data=3'b111, word_cnt=1.
- 127 accepts of 3'b000 after seed 7'h01 → the output sequence equals the PRBS7 low bits, and the 128th output is 3'b001 again. Assert rst mid-stream while out_valid=1 → next cycle out_valid=0, running=0.
